// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH slices carrying valid, ctrl,
// two data words and a destination register, with stall, flush and occupancy.

module pipe_stage_slice #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int RN_W   = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data0_i,
  input  logic [DATA_W-1:0] data1_i,
  input  logic [RN_W-1:0]   rn_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data0_o,
  output logic [DATA_W-1:0] data1_o,
  output logic [RN_W-1:0]   rn_o
);
  logic              valid_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic [DATA_W-1:0] data0_q, data1_q;
  logic [RN_W-1:0]   rn_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data0_q <= '0;
      data1_q <= '0;
      rn_q    <= '0;
    end else if (flush) begin
      // Data words keep their value; only the fields that can cause writes are cleared.
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      rn_q    <= '0;
    end else if (!stall) begin
      valid_q <= valid_i;
      ctrl_q  <= valid_i ? ctrl_i : '0;
      rn_q    <= valid_i ? rn_i : '0;
      data0_q <= data0_i;
      data1_q <= data1_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data0_o = data0_q;
  assign data1_o = data1_q;
  assign rn_o    = rn_q;
endmodule

module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 3,
  parameter int RN_W   = 5,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data0,
  input  logic [DATA_W-1:0] in_data1,
  input  logic [RN_W-1:0]   in_rn,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [RN_W-1:0]   out_rn,
  output logic              busy,
  output logic [CNT_W-1:0]  occupancy
);
  if (DEPTH < 1 || DEPTH > 8 || (2 ** CNT_W) <= DEPTH) begin : g_bad_cfg
    $error("pipe_stage_reg: DEPTH must be 1..8 and 2**CNT_W > DEPTH");
  end

  // Index 0 is the upstream input, index k+1 is the output of slice k.
  logic [DEPTH:0]             v_chain;
  logic [DEPTH:0][CTRL_W-1:0] c_chain;
  logic [DEPTH:0][DATA_W-1:0] d0_chain, d1_chain;
  logic [DEPTH:0][RN_W-1:0]   rn_chain;

  assign v_chain[0]  = in_valid;
  assign c_chain[0]  = in_ctrl;
  assign d0_chain[0] = in_data0;
  assign d1_chain[0] = in_data1;
  assign rn_chain[0] = in_rn;

  for (genvar k = 0; k < DEPTH; k++) begin : g_slice
    pipe_stage_slice #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RN_W(RN_W)) u_slice (
      .clock   (clock),
      .resetn  (resetn),
      .stall   (stall),
      .flush   (flush),
      .valid_i (v_chain[k]),
      .ctrl_i  (c_chain[k]),
      .data0_i (d0_chain[k]),
      .data1_i (d1_chain[k]),
      .rn_i    (rn_chain[k]),
      .valid_o (v_chain[k+1]),
      .ctrl_o  (c_chain[k+1]),
      .data0_o (d0_chain[k+1]),
      .data1_o (d1_chain[k+1]),
      .rn_o    (rn_chain[k+1])
    );
  end

  // Next-state valid vector mirrors the slice priority so the count lands on the same edge.
  logic [DEPTH-1:0] vld_d;
  logic [CNT_W-1:0] occ_d, occ_q;

  always_comb begin
    vld_d = '0;
    if (resetn && !flush) vld_d = stall ? v_chain[DEPTH:1] : v_chain[DEPTH-1:0];
    occ_d = '0;
    for (int k = 0; k < DEPTH; k++) occ_d = occ_d + CNT_W'(vld_d[k]);
  end

  always_ff @(posedge clock) begin
    if (!resetn) occ_q <= '0;
    else         occ_q <= occ_d;
  end

  assign out_valid = v_chain[DEPTH];
  assign out_ctrl  = out_valid ? c_chain[DEPTH] : '0;
  assign out_rn    = out_valid ? rn_chain[DEPTH] : '0;
  assign out_data0 = d0_chain[DEPTH];
  assign out_data1 = d1_chain[DEPTH];
  assign occupancy = occ_q;
  assign busy      = (occ_q != '0);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed table on a DEPTH=2 instance plus random traffic
// on DEPTH=2 (with stall/flush) and DEPTH=1 (legacy mode) against a behavioural model.

module tb_pipe_stage_reg;
  typedef struct packed {
    logic        v;
    logic [2:0]  c;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [4:0]  rn;
  } ent_t;

  typedef ent_t pipe_t [8];

  typedef struct {
    bit   rstn, st, fl;
    ent_t in;
    ent_t exp;
    int   occ;
  } row_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        resetn, st2, fl2, st1, fl1;
  logic        in_v;
  logic [2:0]  in_c;
  logic [31:0] in_d0, in_d1;
  logic [4:0]  in_rn;

  logic        o2_v, o2_busy, o1_v, o1_busy;
  logic [2:0]  o2_c, o1_c;
  logic [31:0] o2_d0, o2_d1, o1_d0, o1_d1;
  logic [4:0]  o2_rn, o1_rn;
  logic [3:0]  o2_occ, o1_occ;

  pipe_stage_reg #(.DEPTH(2)) dut2 (
    .clock(clock), .resetn(resetn), .stall(st2), .flush(fl2),
    .in_valid(in_v), .in_ctrl(in_c), .in_data0(in_d0), .in_data1(in_d1), .in_rn(in_rn),
    .out_valid(o2_v), .out_ctrl(o2_c), .out_data0(o2_d0), .out_data1(o2_d1), .out_rn(o2_rn),
    .busy(o2_busy), .occupancy(o2_occ)
  );

  pipe_stage_reg #(.DEPTH(1)) dut1 (
    .clock(clock), .resetn(resetn), .stall(st1), .flush(fl1),
    .in_valid(in_v), .in_ctrl(in_c), .in_data0(in_d0), .in_data1(in_d1), .in_rn(in_rn),
    .out_valid(o1_v), .out_ctrl(o1_c), .out_data0(o1_d0), .out_data1(o1_d1), .out_rn(o1_rn),
    .busy(o1_busy), .occupancy(o1_occ)
  );

  int checks = 0;
  int fails  = 0;
  pipe_t m2, m1;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a list of DEPTH entries that shifts by one on advance.
  function automatic pipe_t step(pipe_t s, int depth, bit rstn, bit st, bit fl, ent_t in);
    pipe_t n = s;
    if (!rstn) begin
      for (int k = 0; k < 8; k++) n[k] = '0;
    end else if (fl) begin
      for (int k = 0; k < 8; k++) begin n[k].v = 0; n[k].c = 0; n[k].rn = 0; end
    end else if (!st) begin
      for (int k = depth - 1; k > 0; k--) n[k] = s[k-1];
      n[0] = in;
      if (!in.v) begin n[0].c = 0; n[0].rn = 0; end
    end
    return n;
  endfunction

  function automatic int count_valid(pipe_t s, int depth);
    int c = 0;
    for (int k = 0; k < depth; k++) c += int'(s[k].v);
    return c;
  endfunction

  task automatic cyc(bit rstn, bit s2, bit f2, ent_t in);
    resetn = rstn; st2 = s2; fl2 = f2; st1 = 0; fl1 = 0;
    in_v = in.v; in_c = in.c; in_d0 = in.d0; in_d1 = in.d1; in_rn = in.rn;
    @(posedge clock);
    #1;
    m2 = step(m2, 2, rstn, s2, f2, in);
    m1 = step(m1, 1, rstn, 1'b0, 1'b0, in);
  endtask

  task automatic chk_models;
    int o2 = count_valid(m2, 2);
    int o1 = count_valid(m1, 1);
    chk("m2_valid", o2_v, m2[1].v);    chk("m2_ctrl", o2_c, m2[1].c);
    chk("m2_data0", o2_d0, m2[1].d0);  chk("m2_data1", o2_d1, m2[1].d1);
    chk("m2_rn", o2_rn, m2[1].rn);     chk("m2_occ", o2_occ, o2);
    chk("m2_busy", o2_busy, o2 != 0);
    chk("m1_valid", o1_v, m1[0].v);    chk("m1_ctrl", o1_c, m1[0].c);
    chk("m1_data0", o1_d0, m1[0].d0);  chk("m1_data1", o1_d1, m1[0].d1);
    chk("m1_rn", o1_rn, m1[0].rn);     chk("m1_occ", o1_occ, o1);
    chk("m1_busy", o1_busy, o1 != 0);
  endtask

  function automatic row_t r(bit rstn, bit st, bit fl, ent_t in, ent_t exp, int occ);
    row_t x;
    x.rstn = rstn; x.st = st; x.fl = fl; x.in = in; x.exp = exp; x.occ = occ;
    return x;
  endfunction

  initial begin
    ent_t A  = '{1'b1, 3'b101, 32'h12345678, 32'hCAFEF00D, 5'd9};
    ent_t B  = '{1'b1, 3'b011, 32'h00001111, 32'h00002222, 5'd3};
    ent_t C  = '{1'b1, 3'b110, 32'h00003333, 32'h00004444, 5'd7};
    ent_t D  = '{1'b1, 3'b010, 32'h00005555, 32'h00006666, 5'd12};
    ent_t X  = '{1'b0, 3'b111, 32'h0000DEAD, 32'h0000BEEF, 5'd31};
    ent_t Z  = '0;
    ent_t XQ = '{1'b0, 3'b000, 32'h0000DEAD, 32'h0000BEEF, 5'd0};
    ent_t AF = '{1'b0, 3'b000, 32'h12345678, 32'hCAFEF00D, 5'd0};
    ent_t BF = '{1'b0, 3'b000, 32'h00001111, 32'h00002222, 5'd0};
    row_t tbl[$];
    ent_t rin;

    tbl.push_back(r(0,0,0, A, Z, 0));   // reset
    tbl.push_back(r(0,0,0, A, Z, 0));
    tbl.push_back(r(1,0,0, A, Z, 1));   // A captured, latency 2
    tbl.push_back(r(1,0,0, B, A, 2));
    tbl.push_back(r(1,1,0, C, A, 2));   // stall x3, C waiting
    tbl.push_back(r(1,1,0, C, A, 2));
    tbl.push_back(r(1,1,0, C, A, 2));
    tbl.push_back(r(1,0,0, C, B, 2));   // release: B then C
    tbl.push_back(r(1,0,0, X, C, 1));   // bubble in
    tbl.push_back(r(1,0,0, X, XQ, 0));  // bubble out qualified
    tbl.push_back(r(1,0,0, A, XQ, 1));
    tbl.push_back(r(1,0,0, B, A, 2));
    tbl.push_back(r(1,1,1, C, AF, 0));  // flush+stall on full pipe
    tbl.push_back(r(1,0,0, A, BF, 1));
    tbl.push_back(r(1,0,0, B, A, 2));
    tbl.push_back(r(0,1,0, C, Z, 0));   // reset while stalled and full
    tbl.push_back(r(1,0,0, D, Z, 1));
    tbl.push_back(r(1,0,0, X, D, 1));
    tbl.push_back(r(1,0,0, X, XQ, 0));

    for (int i = 0; i < 8; i++) begin m2[i] = '0; m1[i] = '0; end

    foreach (tbl[i]) begin
      cyc(tbl[i].rstn, tbl[i].st, tbl[i].fl, tbl[i].in);
      chk($sformatf("t%0d_valid", i), o2_v, tbl[i].exp.v);
      chk($sformatf("t%0d_ctrl", i), o2_c, tbl[i].exp.c);
      chk($sformatf("t%0d_data0", i), o2_d0, tbl[i].exp.d0);
      chk($sformatf("t%0d_data1", i), o2_d1, tbl[i].exp.d1);
      chk($sformatf("t%0d_rn", i), o2_rn, tbl[i].exp.rn);
      chk($sformatf("t%0d_occ", i), o2_occ, tbl[i].occ);
      chk($sformatf("t%0d_busy", i), o2_busy, tbl[i].occ != 0);
      chk_models();
    end

    // Random traffic: DEPTH=1 stays in legacy mode, DEPTH=2 sees stall/flush too.
    for (int i = 0; i < 1000; i++) begin
      rin.v  = 1'($urandom_range(0, 1));
      rin.c  = 3'($urandom);
      rin.d0 = $urandom;
      rin.d1 = $urandom;
      rin.rn = 5'($urandom);
      cyc(1'b1, $urandom_range(0, 4) == 0, $urandom_range(0, 19) == 0, rin);
      chk_models();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
